i2s_adc_rx: RTL and testbench

I2S slave receiver for the audio codec's ADC path. It oversamples externally generated `adclrc`, `bclk` and `adcdat` on the 50 MHz system clock and deserializes one left/right sample pair per frame. Each complete pair is presented on parallel outputs with a one-cycle valid strobe. It is the capture-side counterpart of the DAC serializer and feeds the recording/loopback datapath.

---
 rtl/i2s_adc_rx.sv | 166 ++++++++++++++++
 tb/tb_i2s_adc_rx.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_adc_rx.sv
// i2s_adc_rx: I2S slave receiver for the codec ADC path.
// Oversamples adclrc/bclk/adcdat on clock_50M, deserializes one MSB-first
// word per channel and presents each complete left/right pair with a
// one-cycle data_valid strobe. Truncated words raise a one-cycle frame_err.
// Build option: define I2S_RX_LJ_EN for left-justified framing (no one-bit
// delay after the LR clock edge); undefined selects standard I2S.
module i2s_adc_rx #(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clock_50M,
  input  logic                  reset,
  input  logic                  adclrc,
  input  logic                  bclk,
  input  logic                  adcdat,
  output logic [DATA_WIDTH-1:0] left_data,
  output logic [DATA_WIDTH-1:0] right_data,
  output logic                  data_valid,
  output logic                  frame_err
);

  localparam int unsigned SYNC_W = 3;
  localparam int unsigned CNT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    WAIT_LRC = 2'd0,
    SKIP     = 2'd1,
    SHIFT    = 2'd2,
    DONE     = 2'd3
  } state_e;

`ifdef I2S_RX_LJ_EN
  localparam state_e ENTRY_STATE = SHIFT;
`else
  localparam state_e ENTRY_STATE = SKIP;
`endif

  // Synchronizer chains: bit 0 = s1, bit 1 = s2, bit 2 = s3
  logic [SYNC_W-1:0] lrc_sync_q,  lrc_sync_d;
  logic [SYNC_W-1:0] bclk_sync_q, bclk_sync_d;
  logic [SYNC_W-1:0] dat_sync_q,  dat_sync_d;

  state_e                state_q,      state_d;
  logic [DATA_WIDTH-1:0] shreg_q,      shreg_d;
  logic [CNT_W-1:0]      bit_cnt_q,    bit_cnt_d;
  logic                  chan_q,       chan_d;
  logic [DATA_WIDTH-1:0] left_hold_q,  left_hold_d;
  logic                  left_vld_q,   left_vld_d;
  logic [DATA_WIDTH-1:0] left_data_q,  left_data_d;
  logic [DATA_WIDTH-1:0] right_data_q, right_data_d;
  logic                  data_valid_q, data_valid_d;
  logic                  frame_err_q,  frame_err_d;

  logic                  lrc_edge_c;
  logic                  bclk_rise_c;
  logic                  dat_bit_c;
  logic [DATA_WIDTH-1:0] word_c;
  logic                  unused_dat_s3;

  // Shift each asynchronous pin into its three-stage chain
  always_comb begin
    lrc_sync_d  = {lrc_sync_q[SYNC_W-2:0],  adclrc};
    bclk_sync_d = {bclk_sync_q[SYNC_W-2:0], bclk};
    dat_sync_d  = {dat_sync_q[SYNC_W-2:0],  adcdat};
  end

  // Edge detection on the synchronized pins; data is sampled at stage 2
  always_comb begin
    lrc_edge_c    = lrc_sync_q[1] != lrc_sync_q[2];
    bclk_rise_c   = bclk_sync_q[1] & ~bclk_sync_q[2];
    dat_bit_c     = dat_sync_q[1];
    // Third data stage keeps the chains equal length; its output is not needed
    unused_dat_s3 = dat_sync_q[2];
    word_c        = {shreg_q[DATA_WIDTH-2:0], dat_bit_c};
  end

  // Framing FSM, deserializer and pair assembly
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    chan_d       = chan_q;
    left_hold_d  = left_hold_q;
    left_vld_d   = left_vld_q;
    left_data_d  = left_data_q;
    right_data_d = right_data_q;
    data_valid_d = 1'b0;
    frame_err_d  = 1'b0;

    if (lrc_edge_c) begin
      // A new half-frame always restarts capture; the coincident bclk rise is dropped
      chan_d    = lrc_sync_q[1];
      bit_cnt_d = CNT_LAST;
      state_d   = ENTRY_STATE;
      if ((state_q == SKIP) || (state_q == SHIFT)) begin
        frame_err_d = 1'b1;
        left_vld_d  = 1'b0;
      end
    end else if (bclk_rise_c) begin
      case (state_q)
        SKIP: begin
          state_d = SHIFT;
        end
        SHIFT: begin
          shreg_d = word_c;
          if (bit_cnt_q == '0) begin
            state_d = DONE;
            if (!chan_q) begin
              left_hold_d = word_c;
              left_vld_d  = 1'b1;
            end else if (left_vld_q) begin
              left_data_d  = left_hold_q;
              right_data_d = word_c;
              data_valid_d = 1'b1;
              left_vld_d   = 1'b0;
            end
          end else begin
            bit_cnt_d = bit_cnt_q - CNT_W'(1);
          end
        end
        default: begin
          // WAIT_LRC and DONE ignore bit clocks until the next LR edge
        end
      endcase
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clock_50M) begin
    if (reset) begin
      lrc_sync_q   <= '0;
      bclk_sync_q  <= '0;
      dat_sync_q   <= '0;
      state_q      <= WAIT_LRC;
      shreg_q      <= '0;
      bit_cnt_q    <= CNT_LAST;
      chan_q       <= 1'b0;
      left_hold_q  <= '0;
      left_vld_q   <= 1'b0;
      left_data_q  <= '0;
      right_data_q <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      lrc_sync_q   <= lrc_sync_d;
      bclk_sync_q  <= bclk_sync_d;
      dat_sync_q   <= dat_sync_d;
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      chan_q       <= chan_d;
      left_hold_q  <= left_hold_d;
      left_vld_q   <= left_vld_d;
      left_data_q  <= left_data_d;
      right_data_q <= right_data_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign left_data  = left_data_q;
  assign right_data = right_data_q;
  assign data_valid = data_valid_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_i2s_adc_rx.sv
// tb_i2s_adc_rx: directed I2S frames checked against a frame-level model.
module tb_i2s_adc_rx;

  localparam int unsigned W = 16;
  localparam int H = 10;  // clock_50M cycles per bclk phase
`ifdef I2S_RX_LJ_EN
  localparam int SKIP = 0;
`else
  localparam int SKIP = 1;
`endif
  localparam int LEAD = SKIP;  // data lead used for "native" frames

  logic         clk    = 1'b0;
  logic         reset  = 1'b1;
  logic         adclrc = 1'b0;
  logic         bclk   = 1'b0;
  logic         adcdat = 1'b0;
  logic [W-1:0] left_data, right_data;
  logic         data_valid, frame_err;

  always #10 clk = ~clk;

  i2s_adc_rx #(.DATA_WIDTH(W)) dut (
    .clock_50M (clk),
    .reset     (reset),
    .adclrc    (adclrc),
    .bclk      (bclk),
    .adcdat    (adcdat),
    .left_data (left_data),
    .right_data(right_data),
    .data_valid(data_valid),
    .frame_err (frame_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Frame-level model: each half-frame is a list of bits seen on bclk rises
  typedef struct packed { logic [W-1:0] l; logic [W-1:0] r; } pair_t;
  pair_t        exp_q[$];
  logic         m_prev, m_busy, m_lvld;
  logic [W-1:0] m_hold;
  int           exp_dv, exp_err, seen_dv, seen_err;
  logic [W-1:0] first_l, first_r;

  task automatic model_reset();
    m_prev = 1'b0;
    m_busy = 1'b0;
    m_lvld = 1'b0;
  endtask

  // first = index of the first rise that can count after the LR edge
  task automatic model_half(input logic ch, input logic [63:0] b, input int first, input int n);
    logic [W-1:0] w;
    pair_t        p;
    if (ch == m_prev) return;  // no LR edge: receiver still waiting for sync
    m_prev = ch;
    if (m_busy) begin
      exp_err++;
      m_lvld = 1'b0;
    end
    if (n - first >= SKIP + int'(W)) begin
      for (int i = 0; i < int'(W); i++) w[int'(W)-1-i] = b[first+SKIP+i];
      m_busy = 1'b0;
      if (!ch) begin
        m_hold = w;
        m_lvld = 1'b1;
      end else if (m_lvld) begin
        p.l = m_hold;
        p.r = w;
        exp_q.push_back(p);
        exp_dv++;
        m_lvld = 1'b0;
      end
    end else begin
      m_busy = 1'b1;
    end
  endtask

  function automatic logic [63:0] mk(input logic [W-1:0] w, input int lead, input logic lead_val);
    logic [63:0] b = '0;
    for (int i = 0; i < 64; i++) begin
      if (i < lead) b[i] = lead_val;
      else if (i < lead + int'(W)) b[i] = w[int'(W)-1-(i-lead)];
    end
    return b;
  endfunction

  // Plays one half-frame; rst_k >= 0 releases (or pulses) reset before rise rst_k
  task automatic half(input logic ch, input logic [63:0] b, input int n, input bit coinc, input int rst_k);
    int first;
    first = coinc ? 1 : 0;
    if (rst_k >= 0) begin
      model_reset();
      first = rst_k;
    end
    model_half(ch, b, first, n);
    if (!coinc) adclrc = ch;
    for (int i = 0; i < n; i++) begin
      if (i == rst_k) begin
        if (reset) reset = 1'b0;
        else begin
          reset = 1'b1;
          @(negedge clk);
          reset = 1'b0;
        end
      end
      adcdat = b[i];
      repeat (H) @(negedge clk);
      bclk = 1'b1;
      if (coinc && i == 0) adclrc = ch;
      repeat (H) @(negedge clk);
      bclk = 1'b0;
    end
  endtask

  task automatic frame(input logic [W-1:0] l, input logic [W-1:0] r, input int lead, input int n);
    half(1'b0, mk(l, lead, 1'b0), n, 1'b0, -1);
    half(1'b1, mk(r, lead, 1'b0), n, 1'b0, -1);
  endtask

  task automatic start_scenario(input bit hold);
    reset  = 1'b1;
    adclrc = 1'b0;
    bclk   = 1'b0;
    adcdat = 1'b0;
    repeat (5) @(negedge clk);
    if (!hold) reset = 1'b0;
    model_reset();
    exp_dv = 0; exp_err = 0; seen_dv = 0; seen_err = 0;
    first_l = '0; first_r = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic end_scenario(input string tag, input int lit_dv, input int lit_err);
    repeat (30) @(negedge clk);
    check({tag, "_dv_vs_model"},  32'(seen_dv),  32'(exp_dv));
    check({tag, "_err_vs_model"}, 32'(seen_err), 32'(exp_err));
    check({tag, "_pending_pairs"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_dv_count"},  32'(seen_dv),  32'(lit_dv));
    check({tag, "_err_count"}, 32'(seen_err), 32'(lit_err));
  endtask

  // Per-cycle output checker against the model, sampled after the active edge
  initial begin : compare
    logic [W-1:0] hold_l, hold_r;
    pair_t        p;
    hold_l = '0;
    hold_r = '0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        check("rst_left",  32'(left_data),  32'd0);
        check("rst_right", 32'(right_data), 32'd0);
        check("rst_valid", 32'(data_valid), 32'd0);
        check("rst_ferr",  32'(frame_err),  32'd0);
        hold_l = '0;
        hold_r = '0;
      end else begin
        if (frame_err) seen_err++;
        if (data_valid) begin
          seen_dv++;
          if (seen_dv == 1) begin
            first_l = left_data;
            first_r = right_data;
          end
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_valid: got left 0x%0h right 0x%0h expected no pulse", left_data, right_data);
          end else begin
            p = exp_q.pop_front();
            check("pair_left",  32'(left_data),  32'(p.l));
            check("pair_right", 32'(right_data), 32'(p.r));
            hold_l = p.l;
            hold_r = p.r;
          end
        end else begin
          check("hold_left",  32'(left_data),  32'(hold_l));
          check("hold_right", 32'(right_data), 32'(hold_r));
        end
      end
    end
  end

  initial begin : stim
    int n4;
    logic [W-1:0] lj_l, lj_r;
    repeat (3) @(negedge clk);

    // Three standard frames after a sync-only right half
    start_scenario(1'b0);
    half(1'b1, mk(16'h0000, LEAD, 1'b0), 32, 1'b0, -1);
    for (int f = 0; f < 3; f++) frame(16'h1234, 16'hABCD, LEAD, 32);
    end_scenario("std", 3, 0);
    check("std_left",  32'(left_data),  32'h1234);
    check("std_right", 32'(right_data), 32'hABCD);

    // Reset released partway through the right word of frame 0
    start_scenario(1'b1);
    half(1'b0, mk(16'h5555, LEAD, 1'b0), 32, 1'b0, -1);
    half(1'b1, mk(16'h6666, LEAD, 1'b0), 32, 1'b0, 5);
    frame(16'h1111, 16'h2222, LEAD, 32);
    frame(16'h3333, 16'h4444, LEAD, 32);
    end_scenario("midrel", 2, 0);
    check("midrel_first_left",  32'(first_l), 32'h1111);
    check("midrel_first_right", 32'(first_r), 32'h2222);
    check("midrel_left",  32'(left_data),  32'h3333);
    check("midrel_right", 32'(right_data), 32'h4444);

    // Right word cut after 10 bits, then a clean frame
    start_scenario(1'b0);
    half(1'b1, mk(16'h0000, LEAD, 1'b0), 32, 1'b0, -1);
    half(1'b0, mk(16'h0F0F, LEAD, 1'b0), 32, 1'b0, -1);
    half(1'b1, mk(16'hF0F0, LEAD, 1'b0), LEAD + 10, 1'b0, -1);
    frame(16'h8001, 16'h7FFE, LEAD, 32);
    end_scenario("trunc", 1, 1);
    check("trunc_left",  32'(left_data),  32'h8001);
    check("trunc_right", 32'(right_data), 32'h7FFE);

    // LR and bit-clock edges land together; the coincident rise carries junk
    start_scenario(1'b0);
    n4 = 1 + SKIP + int'(W);
    half(1'b1, mk(16'h0000, 1 + SKIP, 1'b1), n4, 1'b1, -1);
    half(1'b0, mk(16'hFFFF, 1 + SKIP, 1'b0), n4, 1'b1, -1);
    half(1'b1, mk(16'h0000, 1 + SKIP, 1'b1), n4, 1'b1, -1);
    end_scenario("coinc", 1, 0);
    check("coinc_left",  32'(left_data),  32'hFFFF);
    check("coinc_right", 32'(right_data), 32'h0000);

    // One-cycle reset in the middle of a left word
    start_scenario(1'b0);
    half(1'b1, mk(16'h0000, LEAD, 1'b0), 32, 1'b0, -1);
    frame(16'h0F0F, 16'hF0F0, LEAD, 32);
    half(1'b0, mk(16'h1357, LEAD, 1'b0), 32, 1'b0, 8);
    half(1'b1, mk(16'h2468, LEAD, 1'b0), 32, 1'b0, -1);
    frame(16'hCAFE, 16'hBEEF, LEAD, 32);
    end_scenario("rstpulse", 2, 0);
    check("rstpulse_first_left", 32'(first_l), 32'h0F0F);
    check("rstpulse_left",  32'(left_data),  32'hCAFE);
    check("rstpulse_right", 32'(right_data), 32'hBEEF);

    // Left-justified stream, trailing bits driven 0
    start_scenario(1'b0);
    half(1'b1, mk(16'h0000, 0, 1'b0), 32, 1'b0, -1);
    frame(16'h5A5A, 16'hA5A5, 0, 32);
`ifdef I2S_RX_LJ_EN
    lj_l = 16'h5A5A;
    lj_r = 16'hA5A5;
`else
    lj_l = 16'hB4B4;
    lj_r = 16'h4B4A;
`endif
    end_scenario("lj", 1, 0);
    check("lj_left",  32'(left_data),  32'(lj_l));
    check("lj_right", 32'(right_data), 32'(lj_r));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
